// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the CPU-word / host-line burst memory controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_IDLE,
        ST_WFILL,
        ST_WBUBBLE,
        ST_WISSUE,
        ST_RISSUE,
        ST_RDRAIN,
        ST_DONE
    } state_e;

    function automatic int calc_wpl(input int cl_bits, input int word_bits);
        return cl_bits / word_bits;
    endfunction

    function automatic int calc_line_bytes(input int cl_bits);
        return cl_bits / 8;
    endfunction

endpackage

// File: rtl/mem_line_buf.sv
// One cache line of storage: words shift in from the top, whole lines load in
// parallel, and any single word can be read out by index.
module mem_line_buf #(
    parameter int WORD_SIZE     = 32,
    parameter int CL_SIZE_WIDTH = 512,
    parameter int IDX_W         = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_shift,
    input  logic                     i_load,
    input  logic [WORD_SIZE-1:0]     i_word,
    input  logic [CL_SIZE_WIDTH-1:0] i_line,
    input  logic [IDX_W-1:0]         i_idx,
    output logic [WORD_SIZE-1:0]     o_word,
    output logic [CL_SIZE_WIDTH-1:0] o_line
);

    logic [CL_SIZE_WIDTH-1:0] r_line;

    // Shifting in at the top leaves the first word of a full line in the lowest slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line <= '0;
        end else if (i_load) begin
            r_line <= i_line;
        end else if (i_shift) begin
            r_line <= {i_word, r_line[CL_SIZE_WIDTH-1:WORD_SIZE]};
        end
    end

    assign o_word = r_line[i_idx*WORD_SIZE +: WORD_SIZE];
    assign o_line = r_line;

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst controller between the CPU word port and the host DMA line port:
// packs words into lines for host writes and unpacks host lines for CPU reads.
module mem_burst_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WORD_SIZE     = 32,
    parameter int CL_SIZE_WIDTH = 512,
    parameter int ADDR_BITCOUNT = 64,
    parameter int MAX_BURST     = 8,
    parameter int BUBBLE_CYCLES = 1,
    parameter int LW            = $clog2(MAX_BURST) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_host_init,
    input  logic [ADDR_BITCOUNT-1:0] i_address_offset,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [1:0]               i_req_op,
    input  logic [ADDR_BITCOUNT-1:0] i_req_addr,
    input  logic [LW-1:0]            i_req_lines,
    input  logic [WORD_SIZE-1:0]     i_wr_data,
    input  logic                     i_wr_valid,
    output logic                     o_wr_ready,
    output logic [WORD_SIZE-1:0]     o_rd_data,
    output logic                     o_rd_valid,
    input  logic                     i_rd_ready,
    output logic                     o_rd_last,
    output logic [ADDR_BITCOUNT-1:0] o_host_addr,
    input  logic [CL_SIZE_WIDTH-1:0] i_host_data_in,
    output logic [CL_SIZE_WIDTH-1:0] o_host_data_out,
    input  logic                     i_host_rd_ready,
    input  logic                     i_host_wr_ready,
    output logic                     o_host_rgo,
    output logic                     o_host_wgo,
    output logic                     o_host_re,
    output logic                     o_host_we,
    output logic                     o_ready,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);

    localparam int WPL = calc_wpl(CL_SIZE_WIDTH, WORD_SIZE);
    localparam int WW  = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int BW  = $clog2(BUBBLE_CYCLES + 1);
    localparam logic [ADDR_BITCOUNT-1:0] LINE_INC = ADDR_BITCOUNT'(calc_line_bytes(CL_SIZE_WIDTH));

    state_e                   r_state;
    state_e                   w_next_state;
    logic [LW-1:0]            r_lines;
    logic [LW-1:0]            r_line_idx;
    logic [WW-1:0]            r_word_idx;
    logic [BW-1:0]            r_bubble_cnt;
    logic [ADDR_BITCOUNT-1:0] r_host_addr;
    logic                     r_err;

    logic                     w_req_ok;
    logic                     w_last_word;
    logic                     w_last_line;
    logic                     w_wr_hs;
    logic                     w_host_rd_hs;
    logic [WORD_SIZE-1:0]     w_buf_word;

    assign w_req_ok     = (i_req_lines != '0) && (i_req_lines <= LW'(MAX_BURST)) && (i_req_op != 2'b10);
    assign w_last_word  = (r_word_idx == WW'(WPL - 1));
    assign w_last_line  = ((r_line_idx + LW'(1)) == r_lines);
    assign w_wr_hs      = (r_state == ST_WFILL) && i_wr_valid;
    assign w_host_rd_hs = (r_state == ST_RISSUE) && i_host_rd_ready;

    mem_line_buf #(
        .WORD_SIZE     (WORD_SIZE),
        .CL_SIZE_WIDTH (CL_SIZE_WIDTH),
        .IDX_W         (WW)
    ) u_line_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_shift(w_wr_hs),
        .i_load (w_host_rd_hs),
        .i_word (i_wr_data),
        .i_line (i_host_data_in),
        .i_idx  (r_word_idx),
        .o_word (w_buf_word),
        .o_line (o_host_data_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_STARTUP;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_req_ready  = 1'b0;
        o_wr_ready   = 1'b0;
        o_rd_valid   = 1'b0;
        o_rd_data    = '0;
        o_rd_last    = 1'b0;
        o_host_rgo   = 1'b0;
        o_host_wgo   = 1'b0;
        o_host_re    = 1'b0;
        o_host_we    = 1'b0;
        o_done       = 1'b0;
        o_ready      = (r_state != ST_STARTUP);
        o_busy       = (r_state != ST_STARTUP) && (r_state != ST_IDLE);
        o_err        = r_err;
        o_host_addr  = r_host_addr;
        case (r_state)
            ST_STARTUP: begin
                if (i_host_init) w_next_state = ST_IDLE;
            end
            ST_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid && w_req_ok) begin
                    if (i_req_op == OP_READ)       w_next_state = ST_RISSUE;
                    else if (i_req_op == OP_WRITE) w_next_state = ST_WFILL;
                end
            end
            ST_WFILL: begin
                o_wr_ready = 1'b1;
                if (i_wr_valid && w_last_word) w_next_state = ST_WBUBBLE;
            end
            ST_WBUBBLE: begin
                o_host_wgo = 1'b1;
                if (r_bubble_cnt == BW'(BUBBLE_CYCLES - 1)) w_next_state = ST_WISSUE;
            end
            ST_WISSUE: begin
                o_host_wgo = 1'b1;
                if (i_host_wr_ready) begin
                    o_host_we    = 1'b1;
                    w_next_state = w_last_line ? ST_DONE : ST_WFILL;
                end
            end
            ST_RISSUE: begin
                o_host_rgo = 1'b1;
                if (i_host_rd_ready) begin
                    o_host_re    = 1'b1;
                    w_next_state = ST_RDRAIN;
                end
            end
            ST_RDRAIN: begin
                o_rd_valid = 1'b1;
                o_rd_data  = w_buf_word;
                o_rd_last  = w_last_word && w_last_line;
                if (i_rd_ready && w_last_word) w_next_state = w_last_line ? ST_DONE : ST_RISSUE;
            end
            ST_DONE: begin
                o_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_STARTUP;
        endcase
    end

    // Burst bookkeeping; the address register wraps silently at the top of the address space.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lines      <= '0;
            r_line_idx   <= '0;
            r_word_idx   <= '0;
            r_bubble_cnt <= '0;
            r_host_addr  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        if (w_req_ok) begin
                            r_lines     <= i_req_lines;
                            r_host_addr <= i_req_addr + i_address_offset;
                            r_line_idx  <= '0;
                            r_word_idx  <= '0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_WFILL: begin
                    r_bubble_cnt <= '0;
                    if (i_wr_valid) r_word_idx <= w_last_word ? '0 : r_word_idx + WW'(1);
                end
                ST_WBUBBLE: begin
                    r_bubble_cnt <= r_bubble_cnt + BW'(1);
                end
                ST_WISSUE: begin
                    if (i_host_wr_ready && !w_last_line) begin
                        r_host_addr <= r_host_addr + LINE_INC;
                        r_line_idx  <= r_line_idx + LW'(1);
                    end
                end
                ST_RISSUE: begin
                    if (i_host_rd_ready) r_word_idx <= '0;
                end
                ST_RDRAIN: begin
                    if (i_rd_ready) begin
                        if (w_last_word) begin
                            r_word_idx <= '0;
                            if (!w_last_line) begin
                                r_host_addr <= r_host_addr + LINE_INC;
                                r_line_idx  <= r_line_idx + LW'(1);
                            end
                        end else begin
                            r_word_idx <= r_word_idx + WW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl: reset, write/read bursts, rejects, bubble timing,
// mid-burst reset and address wrap.
module tb_mem_burst_ctrl;

    localparam int WS  = 32;
    localparam int CL  = 512;
    localparam int AW  = 64;
    localparam int LW  = 4;
    localparam int WPL = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_host_init = 1'b0;
    logic [AW-1:0] i_address_offset = '0;
    logic          i_req_valid = 1'b0;
    logic          o_req_ready;
    logic [1:0]    i_req_op = 2'b00;
    logic [AW-1:0] i_req_addr = '0;
    logic [LW-1:0] i_req_lines = '0;
    logic [WS-1:0] i_wr_data = '0;
    logic          i_wr_valid = 1'b0;
    logic          o_wr_ready;
    logic [WS-1:0] o_rd_data;
    logic          o_rd_valid;
    logic          i_rd_ready = 1'b0;
    logic          o_rd_last;
    logic [AW-1:0] o_host_addr;
    logic [CL-1:0] i_host_data_in = '0;
    logic [CL-1:0] o_host_data_out;
    logic          i_host_rd_ready = 1'b0;
    logic          i_host_wr_ready = 1'b0;
    logic          o_host_rgo, o_host_wgo, o_host_re, o_host_we;
    logic          o_ready, o_busy, o_done, o_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_burst_ctrl #(
        .WORD_SIZE(WS), .CL_SIZE_WIDTH(CL), .ADDR_BITCOUNT(AW),
        .MAX_BURST(8), .BUBBLE_CYCLES(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_host_init(i_host_init),
        .i_address_offset(i_address_offset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_op(i_req_op),
        .i_req_addr(i_req_addr), .i_req_lines(i_req_lines),
        .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
        .o_rd_last(o_rd_last), .o_host_addr(o_host_addr),
        .i_host_data_in(i_host_data_in), .o_host_data_out(o_host_data_out),
        .i_host_rd_ready(i_host_rd_ready), .i_host_wr_ready(i_host_wr_ready),
        .o_host_rgo(o_host_rgo), .o_host_wgo(o_host_wgo),
        .o_host_re(o_host_re), .o_host_we(o_host_we),
        .o_ready(o_ready), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic host_init_pulse();
        i_host_init = 1'b1;
        next_cycle();
        i_host_init = 1'b0;
    endtask

    task automatic issue_req(input logic [1:0] op, input logic [AW-1:0] addr, input logic [LW-1:0] lines);
        i_req_valid = 1'b1;
        i_req_op    = op;
        i_req_addr  = addr;
        i_req_lines = lines;
        @(negedge clk);
        checks++;
        if (o_req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL req_accept: req_ready=%b expected 1", o_req_ready);
        end
        next_cycle();
        i_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_req_valid = 1'b1;
        i_req_op    = 2'b01;
        i_req_lines = 4'd1;
        #2;
        checks++;
        if ({o_ready, o_busy, o_req_ready, o_host_rgo, o_host_wgo, o_done, o_err, o_rd_valid} !== 8'b0
            || o_host_addr !== '0 || o_host_data_out !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: ready=%b busy=%b rgo=%b addr=%h expected all zero",
                     o_ready, o_busy, o_host_rgo, o_host_addr);
        end
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (o_ready !== 1'b0 || o_req_ready !== 1'b0 || o_host_rgo !== 1'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL startup_hold: ready=%b req_ready=%b rgo=%b busy=%b expected 0 0 0 0",
                         o_ready, o_req_ready, o_host_rgo, o_busy);
            end
            next_cycle();
        end
        i_req_valid = 1'b0;
    endtask

    task automatic test_write_burst();
        logic [CL-1:0] exp_line;
        logic [AW-1:0] exp_addr;
        int nxt = 0;
        int we_cnt = 0;
        int done_cnt = 0;
        int post = -1;
        logic hs;
        host_init_pulse();
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL init_ready: ready=%b busy=%b expected 1 0", o_ready, o_busy);
        end
        next_cycle();
        i_address_offset = 64'h40;
        i_host_wr_ready  = 1'b1;
        issue_req(2'b11, 64'h1000, 4'd2);
        for (int c = 0; c < 300 && post != 0; c++) begin
            i_wr_valid = (nxt < 2 * WPL) && ((c % 5) != 3);
            i_wr_data  = 32'(nxt);
            @(negedge clk);
            hs = o_wr_ready && i_wr_valid;
            if (o_host_we) begin
                exp_addr = 64'h1040 + 64'(we_cnt) * 64'h40;
                for (int j = 0; j < WPL; j++) exp_line[j*WS +: WS] = 32'(we_cnt * WPL + j);
                checks++;
                if (o_host_addr !== exp_addr || o_host_wgo !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL wr_addr: line %0d host_addr=%h wgo=%b expected %h 1",
                             we_cnt, o_host_addr, o_host_wgo, exp_addr);
                end
                checks++;
                if (o_host_data_out !== exp_line) begin
                    errors++;
                    $display("[TB] FAIL wr_line: line %0d word0=%h word15=%h expected %h %h", we_cnt,
                             o_host_data_out[31:0], o_host_data_out[511:480], exp_line[31:0], exp_line[511:480]);
                end
                we_cnt++;
            end
            if (o_done) begin
                done_cnt++;
                if (post < 0) post = 3;
            end
            next_cycle();
            if (hs) nxt++;
            if (post > 0) post--;
        end
        i_wr_valid = 1'b0;
        checks++;
        if (we_cnt != 2 || done_cnt != 1 || nxt != 2 * WPL) begin
            errors++;
            $display("[TB] FAIL wr_summary: we=%0d done=%0d words=%0d expected 2 1 32", we_cnt, done_cnt, nxt);
        end
    endtask

    task automatic test_read_backpressure();
        logic [WS-1:0] prev_data = '0;
        logic prev_stall = 1'b0;
        int got = 0;
        int re_cnt = 0;
        int done_cnt = 0;
        for (int j = 0; j < WPL; j++) i_host_data_in[j*WS +: WS] = 32'hA0 + 32'(j);
        issue_req(2'b01, 64'h2000, 4'd1);
        for (int c = 0; c < 200 && done_cnt == 0; c++) begin
            i_host_rd_ready = (c >= 3);
            i_rd_ready      = (c % 2) == 1;
            @(negedge clk);
            if (o_host_re) begin
                re_cnt++;
                checks++;
                if (o_host_addr !== 64'h2040) begin
                    errors++;
                    $display("[TB] FAIL rd_addr: host_addr=%h expected 2040", o_host_addr);
                end
            end
            if (prev_stall) begin
                checks++;
                if (o_rd_valid !== 1'b1 || o_rd_data !== prev_data) begin
                    errors++;
                    $display("[TB] FAIL rd_hold: valid=%b data=%h expected 1 %h", o_rd_valid, o_rd_data, prev_data);
                end
            end
            if (o_rd_valid) begin
                checks++;
                if (o_rd_data !== 32'hA0 + 32'(got) || o_rd_last !== (got == WPL - 1)) begin
                    errors++;
                    $display("[TB] FAIL rd_word: data=%h last=%b expected %h %b",
                             o_rd_data, o_rd_last, 32'hA0 + 32'(got), (got == WPL - 1));
                end
                if (i_rd_ready) got++;
            end
            prev_stall = o_rd_valid && !i_rd_ready;
            prev_data  = o_rd_data;
            if (o_done) done_cnt++;
            next_cycle();
        end
        i_host_rd_ready = 1'b0;
        i_rd_ready      = 1'b0;
        checks++;
        if (got != WPL || re_cnt != 1 || done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL rd_summary: words=%0d re=%0d done=%0d expected 16 1 1", got, re_cnt, done_cnt);
        end
    endtask

    task automatic test_reject();
        logic [1:0]    ops[3]   = '{2'b01, 2'b11, 2'b10};
        logic [LW-1:0] lines[3] = '{4'd0, 4'd9, 4'd1};
        for (int k = 0; k < 3; k++) begin
            issue_req(ops[k], 64'h5000, lines[k]);
            @(negedge clk);
            checks++;
            if (o_err !== 1'b1 || o_req_ready !== 1'b1 || o_busy !== 1'b0
                || {o_host_rgo, o_host_wgo, o_host_re, o_host_we} !== 4'b0) begin
                errors++;
                $display("[TB] FAIL reject_%0d: err=%b req_ready=%b busy=%b strobes=%b expected 1 1 0 0000", k,
                         o_err, o_req_ready, o_busy, {o_host_rgo, o_host_wgo, o_host_re, o_host_we});
            end
            next_cycle();
            @(negedge clk);
            checks++;
            if (o_err !== 1'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reject_pulse_%0d: err=%b busy=%b expected 0 0", k, o_err, o_busy);
            end
            next_cycle();
        end
    endtask

    task automatic test_bubble();
        int nxt = 0;
        int last_hs = -100;
        int we_at = -1;
        int done_cnt = 0;
        logic hs;
        i_host_wr_ready = 1'b1;
        issue_req(2'b11, 64'h3000, 4'd1);
        for (int c = 0; c < 100 && done_cnt == 0; c++) begin
            i_wr_valid = (nxt < WPL);
            i_wr_data  = 32'(nxt);
            @(negedge clk);
            hs = o_wr_ready && i_wr_valid;
            if (hs && nxt == WPL - 1) last_hs = c;
            if (c > last_hs && c <= last_hs + 3) begin
                checks++;
                if (o_host_wgo !== 1'b1 || o_host_we !== 1'b0 || o_host_addr !== 64'h3040) begin
                    errors++;
                    $display("[TB] FAIL bubble_hold: cycle+%0d wgo=%b we=%b addr=%h expected 1 0 3040",
                             c - last_hs, o_host_wgo, o_host_we, o_host_addr);
                end
            end
            if (o_host_we && we_at < 0) we_at = c;
            if (o_done) done_cnt++;
            next_cycle();
            if (hs) nxt++;
        end
        i_wr_valid = 1'b0;
        checks++;
        if (last_hs < 0 || we_at != last_hs + 4) begin
            errors++;
            $display("[TB] FAIL bubble_timing: we at %0d cycles after last word, expected 4", we_at - last_hs);
        end
    endtask

    task automatic test_reset_mid_burst();
        int got = 0;
        i_host_rd_ready = 1'b1;
        i_rd_ready      = 1'b1;
        issue_req(2'b01, 64'h4000, 4'd3);
        for (int c = 0; c < 100 && got < 20; c++) begin
            @(negedge clk);
            if (o_rd_valid && i_rd_ready) got++;
            next_cycle();
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_rd_valid, o_rd_last, o_host_rgo, o_host_re, o_host_wgo, o_host_we, o_busy, o_ready,
             o_done, o_err, o_req_ready, o_wr_ready} !== 12'b0
            || o_rd_data !== '0 || o_host_addr !== '0 || o_host_data_out !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: rd_valid=%b rgo=%b re=%b busy=%b addr=%h expected zeros (words=%0d)",
                     o_rd_valid, o_host_rgo, o_host_re, o_busy, o_host_addr, got);
        end
        next_cycle();
        rst_n = 1'b1;
        i_req_valid = 1'b1;
        i_req_op    = 2'b01;
        i_req_lines = 4'd1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (o_rd_valid !== 1'b0 || o_host_rgo !== 1'b0 || o_host_re !== 1'b0 || o_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset_quiet: rd_valid=%b rgo=%b re=%b ready=%b expected 0 0 0 0",
                         o_rd_valid, o_host_rgo, o_host_re, o_ready);
            end
            next_cycle();
        end
        i_req_valid = 1'b0;
        host_init_pulse();
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_rd_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reinit: ready=%b rd_valid=%b busy=%b expected 1 0 0", o_ready, o_rd_valid, o_busy);
        end
        next_cycle();
    endtask

    task automatic test_addr_wrap();
        logic [AW-1:0] exp_addr[2] = '{64'hFFFF_FFFF_FFFF_FFC0, 64'h0};
        int re_cnt = 0;
        int done_cnt = 0;
        i_address_offset = '0;
        i_host_rd_ready  = 1'b1;
        i_rd_ready       = 1'b1;
        issue_req(2'b01, 64'hFFFF_FFFF_FFFF_FFC0, 4'd2);
        for (int c = 0; c < 100 && done_cnt == 0; c++) begin
            @(negedge clk);
            if (o_host_re) begin
                checks++;
                if (re_cnt > 1 || o_host_addr !== exp_addr[re_cnt & 1]) begin
                    errors++;
                    $display("[TB] FAIL wrap_addr: re #%0d host_addr=%h expected %h",
                             re_cnt, o_host_addr, exp_addr[re_cnt & 1]);
                end
                re_cnt++;
            end
            if (o_done) done_cnt++;
            next_cycle();
        end
        i_host_rd_ready = 1'b0;
        i_rd_ready      = 1'b0;
        checks++;
        if (re_cnt != 2 || done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL wrap_summary: re=%0d done=%0d expected 2 1", re_cnt, done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_backpressure();
        test_reject();
        test_bubble();
        test_reset_mid_burst();
        test_addr_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
